// File: rtl/prio_encoder_irq.sv
// prio_encoder_irq: registered active-low priority encoder with per-line mask and valid/ready grant.
// Define PRIO_ENC_EDGE_DETECT_EN to latch requests on 1->0 transitions instead of low levels.
module prio_encoder_irq #(
  parameter int N = 8,
  localparam int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ei,
  input  logic [N-1:0] req_n,
  input  logic [N-1:0] mask,
  output logic         out_valid,
  output logic [W-1:0] out_idx,
  input  logic         out_ready,
  output logic         gs,
  output logic         eo
);
  typedef enum logic {IDLE, PRESENT} state_t;
  state_t r_state;
  logic [N-1:0] r_pend, w_cand, w_set, w_clr;
  logic [W-1:0] w_win;
  logic w_ack;
`ifdef PRIO_ENC_EDGE_DETECT_EN
  logic [N-1:0] r_req_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) r_req_q <= '1;
    else r_req_q <= req_n;
  assign w_set = r_req_q & ~req_n;
`else
  assign w_set = ~req_n;
`endif
  assign w_cand = r_pend & ~mask;
  assign w_ack = out_valid & out_ready;
  assign w_clr = w_ack ? {{(N-1){1'b0}}, 1'b1} << out_idx : '0;
  always_comb begin
    w_win = '0;
    for (int i = 0; i < N; i++) if (w_cand[i]) w_win = W'(i);
  end
  // The ack clear is applied even while disabled so a serviced line is never regranted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pend    <= '0;
      r_state   <= IDLE;
      out_valid <= 1'b0;
      out_idx   <= '0;
    end else begin
      r_pend <= (ei ? r_pend : r_pend | w_set) & ~w_clr;
      if (r_state == IDLE) begin
        if (!ei && |w_cand) begin
          r_state   <= PRESENT;
          out_valid <= 1'b1;
          out_idx   <= w_win;
        end
      end else if (out_ready) begin
        r_state   <= IDLE;
        out_valid <= 1'b0;
      end
    end
  end
  assign gs = ~out_valid;
  assign eo = ei | out_valid | (|w_cand);
endmodule

// File: tb/tb_prio_encoder_irq.sv
// tb_prio_encoder_irq: scoreboard bench for prio_encoder_irq with directed scenarios and random traffic.
module tb_prio_encoder_irq;
  localparam int N = 8;
  localparam int W = $clog2(N);
  logic clk = 0, rst = 1, ei = 0, out_ready = 0;
  logic [N-1:0] req_n = '1, mask = '0;
  logic out_valid, gs, eo;
  logic [W-1:0] out_idx;
  int vectors = 0, miscompares = 0;
  int exp_q[$];
  bit [N-1:0] m_pend;
  bit [N-1:0] m_prev;
  bit m_valid;
  int m_idx;
  bit seen = 0;

  prio_encoder_irq #(.N(N)) dut (
    .clk(clk), .rst(rst), .ei(ei), .req_n(req_n), .mask(mask),
    .out_valid(out_valid), .out_idx(out_idx), .out_ready(out_ready),
    .gs(gs), .eo(eo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int top(input bit [N-1:0] c);
    for (int i = N - 1; i >= 0; i--) if (c[i]) return i;
    return 0;
  endfunction

  task automatic model_reset();
    m_pend = '0; m_prev = '1; m_valid = 0; m_idx = 0;
  endtask

  // Reference model: one call per rising edge, using the inputs held across that edge.
  task automatic model_step();
    bit [N-1:0] cand, set, clr;
    cand = m_pend & ~mask;
`ifdef PRIO_ENC_EDGE_DETECT_EN
    set = m_prev & ~req_n;
`else
    set = ~req_n;
`endif
    clr = '0;
    if (m_valid && out_ready) begin
      clr[m_idx] = 1'b1;
      m_valid = 0;
    end else if (!m_valid && !ei && cand != 0) begin
      m_idx = top(cand);
      m_valid = 1;
      exp_q.push_back(m_idx);
    end
    if (!ei) m_pend |= set;
    m_pend &= ~clr;
    m_prev = req_n;
  endtask

  task automatic check_outputs();
    chk("out_valid", 32'(out_valid), 32'(m_valid));
    chk("out_idx", 32'(out_idx), 32'(m_idx));
    chk("gs", 32'(gs), 32'(!m_valid));
    chk("eo", 32'(eo), 32'(ei || m_valid || ((m_pend & ~mask) != 0)));
  endtask

  task automatic cyc(input logic e, input logic [N-1:0] r, input logic [N-1:0] m, input logic rd);
    @(negedge clk);
    check_outputs();
    ei = e; req_n = r; mask = m; out_ready = rd;
    @(posedge clk);
    model_step();
  endtask

  initial forever begin
    @(negedge clk);
    if (out_valid === 1'b1 && !seen) begin
      seen = 1;
      if (exp_q.size() == 0) begin
        vectors++; miscompares++;
        $display("FAIL unexpected_grant: got idx %0d expected no grant at %0t", out_idx, $time);
      end else chk("grant_idx", 32'(out_idx), 32'(exp_q.pop_front()));
    end else if (out_valid !== 1'b1) seen = 0;
  end

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 0;
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_gs", 32'(gs), 1);
    chk("rst_eo", 32'(eo), 0);
    cyc(1, 8'hFF, 8'h00, 0); #1 chk("ei_eo", 32'(eo), 1);
    // Lines 5 and 3 pulsed together
    cyc(0, 8'b1101_0111, 8'h00, 0);
    cyc(0, 8'hFF, 8'h00, 0); #1 chk("prio_valid", 32'(out_valid), 1);
    chk("prio_idx5", 32'(out_idx), 5);
    cyc(0, 8'hFF, 8'h00, 1);
    cyc(0, 8'hFF, 8'h00, 0); #1 chk("prio_idx3", 32'(out_idx), 3);
    cyc(0, 8'hFF, 8'h00, 1); #1 chk("drain_valid", 32'(out_valid), 0);
    chk("drain_eo", 32'(eo), 0);
    // Mask applied while line 7 is granted
    cyc(0, 8'h7F, 8'h00, 0);
    cyc(0, 8'hFF, 8'h00, 0);
    cyc(0, 8'hFF, 8'h80, 0); #1 chk("mask_hold_idx", 32'(out_idx), 7);
    cyc(0, 8'hFF, 8'h80, 1);
    cyc(0, 8'hFF, 8'h00, 0);
    cyc(0, 8'hFF, 8'h00, 0); #1 chk("mask_no_regrant", 32'(out_valid), 0);
    // Masked line 2 stays pending until unmasked
    repeat (3) cyc(0, 8'hFB, 8'h04, 0);
    #1 chk("masked_valid", 32'(out_valid), 0);
    chk("masked_eo", 32'(eo), 0);
    cyc(0, 8'hFF, 8'h00, 0);
    cyc(0, 8'hFF, 8'h00, 0); #1 chk("unmask_valid", 32'(out_valid), 1);
    chk("unmask_idx", 32'(out_idx), 2);
    cyc(0, 8'hFF, 8'h00, 1);
    // Line 1 held low through its own ack
    cyc(0, 8'hFD, 8'h00, 0);
    cyc(0, 8'hFD, 8'h00, 0);
    cyc(0, 8'hFD, 8'h00, 1);
    repeat (3) cyc(0, 8'hFD, 8'h00, 0);
`ifdef PRIO_ENC_EDGE_DETECT_EN
    #1 chk("collide_no_regrant", 32'(out_valid), 0);
    cyc(0, 8'hFF, 8'h00, 0);
    cyc(0, 8'hFD, 8'h00, 0);
    cyc(0, 8'hFF, 8'h00, 0); #1 chk("retrigger_valid", 32'(out_valid), 1);
`else
    #1 chk("collide_regrant", 32'(out_valid), 1);
`endif
    chk("collide_idx", 32'(out_idx), 1);
    // Asynchronous reset while a grant is presented
    cyc(0, 8'hEF, 8'h00, 0);
    cyc(0, 8'hEF, 8'h00, 0);
    #2 rst = 1; req_n = '1; out_ready = 0;
    #1 chk("arst_valid", 32'(out_valid), 0);
    chk("arst_gs", 32'(gs), 1);
    model_reset();
    exp_q.delete();
    @(negedge clk); rst = 0;
    repeat (3) cyc(0, 8'hFF, 8'h00, 0);
    #1 chk("arst_pending_empty", 32'(out_valid), 0);
    repeat (300)
      cyc(($urandom_range(0, 9) == 0), ~(N'($urandom) & N'($urandom)),
          N'($urandom) & N'($urandom) & N'($urandom), 1'($urandom));
    repeat (24) cyc(0, 8'hFF, 8'h00, 1);
    @(negedge clk);
    check_outputs();
    chk("queue_empty", 32'(exp_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end
endmodule
